// File: rtl/add_out_responder.sv
// Elastic registered adder driving the add_out bus: stage 0 computes a+b+cin,
// later stages are plain registers, and the last stage drives sum/cout/out_valid.
module add_out_responder #(
  parameter int unsigned ADD_WIDTH = 4,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADD_WIDTH-1:0] a,
  input  logic [ADD_WIDTH-1:0] b,
  input  logic                 cin,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ADD_WIDTH-1:0] sum,
  output logic [ADD_WIDTH-1:0] cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] result_count,
  output logic [CNT_WIDTH-1:0] carry_count
);

  localparam int unsigned SUM_W = ADD_WIDTH + 1;
  localparam int unsigned LAST  = LATENCY - 1;

  logic [LATENCY-1:0]   vld_q;
  logic [LATENCY-1:0]   carry_q;
  logic [ADD_WIDTH-1:0] sum_q [LATENCY];
  logic [LATENCY-1:0]   load_c;
  logic [SUM_W-1:0]     add_c;

  assign add_c = SUM_W'(a) + SUM_W'(b) + SUM_W'(cin);

  // A stage may load unless it and every stage downstream of it are full
  // while the bus is stalled.
  always_comb begin : load_gen
    logic all_full;
    all_full = 1'b1;
    load_c   = '0;
    for (int k = int'(LATENCY) - 1; k >= 0; k--) begin
      all_full  = all_full & vld_q[k];
      load_c[k] = out_ready | ~all_full;
    end
  end

  assign in_ready  = load_c[0];
  assign out_valid = vld_q[LAST];
  assign sum       = sum_q[LAST];
  assign cout      = ADD_WIDTH'(carry_q[LAST]);

  // Payload only moves with a valid beat so the bus holds its last value when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q        <= '0;
      carry_q      <= '0;
      result_count <= '0;
      carry_count  <= '0;
      for (int k = 0; k < int'(LATENCY); k++) begin
        sum_q[k] <= '0;
      end
    end else begin
      if (load_c[0]) begin
        vld_q[0] <= in_valid;
        if (in_valid) begin
          sum_q[0]   <= add_c[ADD_WIDTH-1:0];
          carry_q[0] <= add_c[ADD_WIDTH];
        end
      end
      for (int k = 1; k < int'(LATENCY); k++) begin
        if (load_c[k]) begin
          vld_q[k] <= vld_q[k-1];
          if (vld_q[k-1]) begin
            sum_q[k]   <= sum_q[k-1];
            carry_q[k] <= carry_q[k-1];
          end
        end
      end
      if (vld_q[LAST] && out_ready) begin
        result_count <= result_count + CNT_WIDTH'(1);
        if (carry_q[LAST]) begin
          carry_count <= carry_count + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_add_out_responder.sv
// Directed bench for add_out_responder: a transaction-level model (queue of
// accepted sums with accept times) is compared against the bus every cycle.
module tb_add_out_responder;

  localparam int unsigned W   = 4;
  localparam int unsigned LAT = 2;
  localparam int unsigned CW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  sum;
  logic [W-1:0]  cout;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [CW-1:0] result_count;
  logic [CW-1:0] carry_count;

  add_out_responder #(.ADD_WIDTH(W), .LATENCY(LAT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .cout(cout), .out_valid(out_valid), .out_ready(out_ready),
    .result_count(result_count), .carry_count(carry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    int c;
    int n;
  } item_t;

  int    compared   = 0;
  int    mismatched = 0;
  int    ecount     = 0;
  item_t q[$];
  item_t obs[$];
  int    m_rc = 0, m_cc = 0, last_s = 0, last_c = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) ecount++;

  // Model: an accepted pair appears LAT-1 edges after its accept edge once it
  // heads the queue; the pipe is full exactly when LAT results are in flight.
  always @(negedge clk) begin
    bit exp_valid, exp_ready;
    exp_valid = (q.size() > 0) && (ecount >= q[0].n + int'(LAT) - 1);
    exp_ready = (q.size() < int'(LAT)) || out_ready;
    if (exp_valid) begin
      last_s = q[0].s;
      last_c = q[0].c;
    end
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("sum", 32'(sum), 32'(last_s));
    check("cout", 32'(cout), 32'(last_c));
    check("result_count", 32'(result_count), 32'(m_rc % 65536));
    check("carry_count", 32'(carry_count), 32'(m_cc % 65536));
    if (!rst && out_valid && out_ready)
      obs.push_back('{int'(sum), int'(cout), ecount});
    if (rst) begin
      q.delete();
      m_rc = 0; m_cc = 0; last_s = 0; last_c = 0;
    end else begin
      if (exp_valid && out_ready) begin
        m_rc++;
        if (q[0].c != 0) m_cc++;
        void'(q.pop_front());
      end
      if (in_valid && exp_ready) begin
        int t;
        t = int'(a) + int'(b) + int'(cin);
        q.push_back('{t % 16, (t >= 16) ? 1 : 0, ecount + 1});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Called at posedge+2; returns at posedge+2 just after the accept edge.
  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    bit done;
    done = 0;
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int base, acc, iv;

    // Reset held 3 edges with in_valid asserted
    in_valid = 1'b1; a = 4'h5; b = 4'h5;
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_count", 32'(result_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Single add, latency 2
    send(4'd3, 4'd4, 1'b0);
    @(negedge clk);
    check("lat_early_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_sum", 32'(sum), 32'd7);
    check("lat_cout", 32'(cout), 32'd0);
    @(negedge clk);
    check("single_count", 32'(result_count), 32'd1);
    tick();

    // Wrap and carry
    base = obs.size();
    send(4'hF, 4'hF, 1'b1);
    send(4'h8, 4'h8, 1'b0);
    repeat (5) tick();
    check("wrap_n", 32'(obs.size() - base), 32'd2);
    if (obs.size() - base == 2) begin
      check("wrap0_sum", 32'(obs[base].s), 32'hF);
      check("wrap0_cout", 32'(obs[base].c), 32'd1);
      check("wrap1_sum", 32'(obs[base+1].s), 32'd0);
      check("wrap1_cout", 32'(obs[base+1].c), 32'd1);
    end
    check("wrap_carry_count", 32'(carry_count), 32'd2);

    // Backpressure
    base = obs.size();
    out_ready = 1'b0; iv = 0; acc = 0;
    a = 4'd0; b = 4'd0; cin = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (in_ready) begin
        acc++;
        tick();
        iv++; a = 4'(iv); b = 4'(iv);
      end else begin
        check("stall_sum", 32'(sum), 32'd0);
        check("stall_valid", 32'(out_valid), 32'd1);
        tick();
      end
    end
    check("bp_accepts", 32'(acc), 32'(LAT));
    out_ready = 1'b1;
    for (int k = 0; k < 20 && iv < 4; k++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        iv++; a = 4'(iv); b = 4'(iv);
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    repeat (6) tick();
    check("bp_n", 32'(obs.size() - base), 32'd4);
    if (obs.size() - base == 4)
      for (int k = 0; k < 4; k++) check("bp_order", 32'(obs[base+k].s), 32'(2 * k));

    // Full-rate streaming
    base = obs.size();
    for (int i = 0; i < 16; i++) send(4'(i), 4'(15 - i), i[0]);
    repeat (6) tick();
    check("stream_n", 32'(obs.size() - base), 32'd16);
    if (obs.size() - base == 16)
      for (int k = 0; k < 16; k++) begin
        check("stream_sum", 32'(obs[base+k].s), (k % 2 == 1) ? 32'd0 : 32'hF);
        check("stream_cout", 32'(obs[base+k].c), 32'(k % 2));
        if (k > 0) check("stream_gap", 32'(obs[base+k].n - obs[base+k-1].n), 32'd1);
      end
    check("total_results", 32'(result_count), 32'd23);
    check("total_carries", 32'(carry_count), 32'd10);

    // Mid-flight reset
    out_ready = 1'b0;
    send(4'd1, 4'd2, 1'b0);
    send(4'd3, 4'd4, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    base = obs.size();
    repeat (4) begin
      @(negedge clk);
      check("mrst_valid", 32'(out_valid), 32'd0);
      check("mrst_count", 32'(result_count), 32'd0);
      check("mrst_carry", 32'(carry_count), 32'd0);
      tick();
    end
    send(4'd1, 4'd1, 1'b0);
    repeat (5) tick();
    check("mrst_n", 32'(obs.size() - base), 32'd1);
    if (obs.size() - base == 1) check("mrst_sum", 32'(obs[base].s), 32'd2);
    check("mrst_final_count", 32'(result_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
